// File: rtl/atomic_link_unit.sv
// atomic_link_unit
//   Data-side responder between the datapath and the L1 data cache.
//   Forwards plain loads/stores to the cache, holds the LL/SC link register,
//   invalidates the link on matching coherence snoops and returns the SC
//   success flag. A failed SC completes in one response cycle without any
//   cache write.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   dmemREN/dmemWEN      datapath read / write request (REN wins if both)
//   datomic              LL (with REN) or SC (with WEN)
//   dmemaddr/dmemstore   request byte address / store data
//   dhit/dmemload        completion pulse / load data or SC result
//   cREN/cWEN            cache read / write request
//   caddr/cstore         registered request address / store data
//   chit/cload           cache completion / read data
//   snoop_inv/snoop_addr coherence invalidation and its byte address
//
// Configuration
//   LL_TIMEOUT_EN  when defined, the link expires TIMEOUT_CYCLES cycles after
//                  the LL that set it.
module atomic_link_unit #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              datomic,
  input  logic [WORD_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dmemload,
  output logic              cREN,
  output logic              cWEN,
  output logic [WORD_W-1:0] caddr,
  output logic [WORD_W-1:0] cstore,
  input  logic              chit,
  input  logic [WORD_W-1:0] cload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_RESP
  } state_e;

  state_e              state_q;
  logic                is_wr_q;
  logic                is_atom_q;
  logic                cren_q;
  logic                cwen_q;
  logic [WORD_W-1:0]   caddr_q;
  logic [WORD_W-1:0]   cstore_q;

  logic                link_valid_q, link_valid_d;
  logic [WORD_W-3:0]   link_addr_q,  link_addr_d;

  logic                mem_done;
  logic                sc_ok;
  logic                timeout_ok;

  assign mem_done = (state_q == S_MEM) && chit;

`ifdef LL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ll_done;

  assign ll_done    = mem_done && is_atom_q && !is_wr_q;
  assign timeout_ok = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (ll_done) begin
      cnt_d = CNT_W'(TIMEOUT_CYCLES);
    end else if (link_valid_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^snoop_addr[1:0];
`else
  assign timeout_ok = 1'b1;

  logic unused_bits;
  assign unused_bits = (^snoop_addr[1:0]) ^ (|TIMEOUT_CYCLES);
`endif

  // SC success is decided from the registered link while the request sits in IDLE.
  assign sc_ok = link_valid_q && timeout_ok &&
                 (link_addr_q == dmemaddr[WORD_W-1:2]);

  // Link update; later assignments take priority, so the snoop check comes last
  // and compares against the address the link would hold after this cycle.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
`ifdef LL_TIMEOUT_EN
    if (link_valid_q && (cnt_q <= CNT_W'(1))) begin
      link_valid_d = 1'b0;
    end
`endif
    if (mem_done) begin
      if (is_atom_q && !is_wr_q) begin
        link_valid_d = 1'b1;
        link_addr_d  = caddr_q[WORD_W-1:2];
      end else if (is_atom_q) begin
        link_valid_d = 1'b0;
      end else if (is_wr_q && (caddr_q[WORD_W-1:2] == link_addr_q)) begin
        link_valid_d = 1'b0;
      end
    end
    if (state_q == S_RESP) begin
      link_valid_d = 1'b0;
    end
    if (snoop_inv && (snoop_addr[WORD_W-1:2] == link_addr_d)) begin
      link_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      is_atom_q <= 1'b0;
      cren_q    <= 1'b0;
      cwen_q    <= 1'b0;
      caddr_q   <= '0;
      cstore_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dmemREN || dmemWEN) begin
            caddr_q   <= dmemaddr;
            cstore_q  <= dmemstore;
            is_atom_q <= datomic;
            is_wr_q   <= !dmemREN;
            if (!dmemREN && datomic && !sc_ok) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_MEM;
              cren_q  <= dmemREN;
              cwen_q  <= !dmemREN;
            end
          end
        end
        S_MEM: begin
          if (chit) begin
            state_q <= S_IDLE;
            cren_q  <= 1'b0;
            cwen_q  <= 1'b0;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cren_q  <= 1'b0;
          cwen_q  <= 1'b0;
        end
      endcase
    end
  end

  // dhit must coincide with chit, so completion outputs are decoded from state.
  always_comb begin
    dhit     = mem_done || (state_q == S_RESP);
    dmemload = '0;
    if (mem_done) begin
      if (!is_wr_q) begin
        dmemload = cload;
      end else if (is_atom_q) begin
        dmemload = WORD_W'(1);
      end
    end
  end

  assign cREN   = cren_q;
  assign cWEN   = cwen_q;
  assign caddr  = caddr_q;
  assign cstore = cstore_q;

endmodule

// File: tb/tb_atomic_link_unit.sv
// Directed bench for atomic_link_unit (TIMEOUT_CYCLES overridden to 8).
module tb_atomic_link_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic        datomic = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic        dhit;
  logic [31:0] dmemload;
  logic        cREN;
  logic        cWEN;
  logic [31:0] caddr;
  logic [31:0] cstore;
  logic        chit = 1'b0;
  logic [31:0] cload = '0;
  logic        snoop_inv = 1'b0;
  logic [31:0] snoop_addr = '0;

  int n_cmp = 0;
  int n_bad = 0;

  atomic_link_unit #(
    .WORD_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .cREN(cREN), .cWEN(cWEN), .caddr(caddr), .cstore(cstore),
    .chit(chit), .cload(cload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven and outputs sampled 2ns after each rising edge.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_in();
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    chit = 1'b0; snoop_inv = 1'b0;
  endtask

  task automatic do_ll(input logic [31:0] a, input logic [31:0] d);
    dmemREN = 1'b1; datomic = 1'b1; dmemaddr = a; cload = d;
    step();
    chit = 1'b1;
    step();
    idle_in();
  endtask

  task automatic test_reset();
    idle_in();
    nRST = 1'b0;
    #12;
    n_cmp++; if (dhit !== 1'b0) begin n_bad++; $display("FAIL rst_dhit: got %b want 0", dhit); end
    n_cmp++; if (dmemload !== 32'h0) begin n_bad++; $display("FAIL rst_dmemload: got %h want 0", dmemload); end
    n_cmp++; if ({cREN, cWEN} !== 2'b00) begin n_bad++; $display("FAIL rst_cren_cwen: got %b want 00", {cREN, cWEN}); end
    n_cmp++; if ({caddr, cstore} !== 64'h0) begin n_bad++; $display("FAIL rst_caddr_cstore: got %h want 0", {caddr, cstore}); end
    n_cmp++; if (dut.link_valid_q !== 1'b0) begin n_bad++; $display("FAIL rst_link_valid: got %b want 0", dut.link_valid_q); end
    n_cmp++; if (dut.link_addr_q !== 30'h0) begin n_bad++; $display("FAIL rst_link_addr: got %h want 0", dut.link_addr_q); end
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_ll_sc();
    dmemREN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; dmemstore = 32'h0; cload = 32'hDEADBEEF;
    #1;
    n_cmp++; if (dhit !== 1'b0) begin n_bad++; $display("FAIL ll_c0_dhit: got %b want 0", dhit); end
    step();
    n_cmp++; if ({cREN, cWEN} !== 2'b10) begin n_bad++; $display("FAIL ll_cren: got %b want 10", {cREN, cWEN}); end
    n_cmp++; if (caddr !== 32'h100) begin n_bad++; $display("FAIL ll_caddr: got %h want 100", caddr); end
    chit = 1'b1;
    #1;
    n_cmp++; if (dhit !== 1'b1) begin n_bad++; $display("FAIL ll_dhit: got %b want 1", dhit); end
    n_cmp++; if (dmemload !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ll_load: got %h want deadbeef", dmemload); end
    step();
    idle_in();
    #1;
    n_cmp++; if (dhit !== 1'b0) begin n_bad++; $display("FAIL ll_dhit_once: got %b want 0", dhit); end
    n_cmp++; if (dut.link_valid_q !== 1'b1) begin n_bad++; $display("FAIL ll_link_valid: got %b want 1", dut.link_valid_q); end
    n_cmp++; if (dut.link_addr_q !== 30'h40) begin n_bad++; $display("FAIL ll_link_addr: got %h want 40", dut.link_addr_q); end
    dmemWEN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; dmemstore = 32'h5;
    step();
    n_cmp++; if ({cREN, cWEN} !== 2'b01) begin n_bad++; $display("FAIL sc_cwen: got %b want 01", {cREN, cWEN}); end
    n_cmp++; if (cstore !== 32'h5) begin n_bad++; $display("FAIL sc_cstore: got %h want 5", cstore); end
    chit = 1'b1;
    #1;
    n_cmp++; if (dhit !== 1'b1) begin n_bad++; $display("FAIL sc_dhit: got %b want 1", dhit); end
    n_cmp++; if (dmemload !== 32'h1) begin n_bad++; $display("FAIL sc_result: got %h want 1", dmemload); end
    step();
    idle_in();
    #1;
    n_cmp++; if (dut.link_valid_q !== 1'b0) begin n_bad++; $display("FAIL sc_link_clear: got %b want 0", dut.link_valid_q); end
    n_cmp++; if ({dhit, cWEN} !== 2'b00) begin n_bad++; $display("FAIL sc_after: got %b want 00", {dhit, cWEN}); end
  endtask

  task automatic test_sc_fail();
    dmemWEN = 1'b1; datomic = 1'b1; dmemaddr = 32'h200; dmemstore = 32'h77;
    #1;
    n_cmp++; if (cWEN !== 1'b0) begin n_bad++; $display("FAIL scf_c0_cwen: got %b want 0", cWEN); end
    step();
    n_cmp++; if (dhit !== 1'b1) begin n_bad++; $display("FAIL scf_dhit: got %b want 1", dhit); end
    n_cmp++; if (dmemload !== 32'h0) begin n_bad++; $display("FAIL scf_result: got %h want 0", dmemload); end
    n_cmp++; if (cWEN !== 1'b0) begin n_bad++; $display("FAIL scf_cwen: got %b want 0", cWEN); end
    n_cmp++; if (caddr !== 32'h200) begin n_bad++; $display("FAIL scf_caddr: got %h want 200", caddr); end
    idle_in();
    step();
    n_cmp++; if ({dhit, cWEN} !== 2'b00) begin n_bad++; $display("FAIL scf_after: got %b want 00", {dhit, cWEN}); end
  endtask

  task automatic test_snoop();
    do_ll(32'h100, 32'h1111);
    snoop_inv = 1'b1; snoop_addr = 32'h104;
    step();
    snoop_inv = 1'b0;
    n_cmp++; if (dut.link_valid_q !== 1'b1) begin n_bad++; $display("FAIL snoop_other_word: got %b want 1", dut.link_valid_q); end
    snoop_inv = 1'b1; snoop_addr = 32'h103;
    step();
    snoop_inv = 1'b0;
    n_cmp++; if (dut.link_valid_q !== 1'b0) begin n_bad++; $display("FAIL snoop_same_word: got %b want 0", dut.link_valid_q); end
    dmemWEN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; dmemstore = 32'h9;
    step();
    n_cmp++; if ({dhit, cWEN} !== 2'b10) begin n_bad++; $display("FAIL snoop_sc_resp: got %b want 10", {dhit, cWEN}); end
    n_cmp++; if (dmemload !== 32'h0) begin n_bad++; $display("FAIL snoop_sc_result: got %h want 0", dmemload); end
    idle_in();
    step();
  endtask

  task automatic test_snoop_ll_same_cycle();
    dmemREN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; cload = 32'h2222;
    step();
    chit = 1'b1; snoop_inv = 1'b1; snoop_addr = 32'h100;
    step();
    idle_in();
    n_cmp++; if (dut.link_valid_q !== 1'b0) begin n_bad++; $display("FAIL snoop_ll_race: got %b want 0", dut.link_valid_q); end
  endtask

  task automatic test_store_link();
    do_ll(32'h100, 32'h0);
    dmemWEN = 1'b1; dmemaddr = 32'h108; dmemstore = 32'hAA;
    step();
    chit = 1'b1;
    #1;
    n_cmp++; if ({dhit, dmemload} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL sw_resp: got %b/%h want 1/0", dhit, dmemload); end
    step();
    idle_in();
    n_cmp++; if (dut.link_valid_q !== 1'b1) begin n_bad++; $display("FAIL sw_other_keeps: got %b want 1", dut.link_valid_q); end
    dmemWEN = 1'b1; dmemaddr = 32'h101; dmemstore = 32'hBB;
    step();
    chit = 1'b1;
    step();
    idle_in();
    n_cmp++; if (dut.link_valid_q !== 1'b0) begin n_bad++; $display("FAIL sw_same_clears: got %b want 0", dut.link_valid_q); end
  endtask

  task automatic test_priority_and_idle_chit();
    chit = 1'b1;
    #1;
    n_cmp++; if (dhit !== 1'b0) begin n_bad++; $display("FAIL idle_chit_dhit: got %b want 0", dhit); end
    step();
    chit = 1'b0;
    n_cmp++; if ({dhit, cREN, cWEN} !== 3'b000) begin n_bad++; $display("FAIL idle_chit_state: got %b want 000", {dhit, cREN, cWEN}); end
    dmemREN = 1'b1; dmemWEN = 1'b1; dmemaddr = 32'h20; dmemstore = 32'hBB; cload = 32'hCAFE0000;
    step();
    n_cmp++; if ({cREN, cWEN} !== 2'b10) begin n_bad++; $display("FAIL prio_ren: got %b want 10", {cREN, cWEN}); end
    chit = 1'b1;
    #1;
    n_cmp++; if (dmemload !== 32'hCAFE0000) begin n_bad++; $display("FAIL prio_load: got %h want cafe0000", dmemload); end
    step();
    idle_in();
  endtask

  task automatic test_reset_mem();
    dmemREN = 1'b1; dmemaddr = 32'h10; cload = 32'h12345678;
    step();
    n_cmp++; if (cREN !== 1'b1) begin n_bad++; $display("FAIL rstm_cren_pre: got %b want 1", cREN); end
    nRST = 1'b0;
    #1;
    n_cmp++; if ({cREN, dhit} !== 2'b00) begin n_bad++; $display("FAIL rstm_drop: got %b want 00", {cREN, dhit}); end
    dmemREN = 1'b0;
    step();
    n_cmp++; if (dhit !== 1'b0) begin n_bad++; $display("FAIL rstm_nodhit: got %b want 0", dhit); end
    nRST = 1'b1;
    step();
    dmemREN = 1'b1; dmemaddr = 32'h10;
    step();
    n_cmp++; if ({cREN, dhit} !== 2'b10) begin n_bad++; $display("FAIL lw_c1: got %b want 10", {cREN, dhit}); end
    step();
    n_cmp++; if ({cREN, dhit} !== 2'b10) begin n_bad++; $display("FAIL lw_c2_wait: got %b want 10", {cREN, dhit}); end
    chit = 1'b1;
    #1;
    n_cmp++; if ({dhit, dmemload} !== {1'b1, 32'h12345678}) begin n_bad++; $display("FAIL lw_done: got %b/%h want 1/12345678", dhit, dmemload); end
    step();
    idle_in();
    n_cmp++; if ({cREN, dhit, caddr} !== {2'b00, 32'h10}) begin n_bad++; $display("FAIL lw_after: got %b/%h want 00/10", {cREN, dhit}, caddr); end
  endtask

`ifdef LL_TIMEOUT_EN
  task automatic test_timeout();
    do_ll(32'h100, 32'h0);
    repeat (4) step();
    dmemWEN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; dmemstore = 32'h3;
    step();
    n_cmp++; if (cWEN !== 1'b1) begin n_bad++; $display("FAIL to_early_cwen: got %b want 1", cWEN); end
    chit = 1'b1;
    #1;
    n_cmp++; if (dmemload !== 32'h1) begin n_bad++; $display("FAIL to_early_result: got %h want 1", dmemload); end
    step();
    idle_in();
    do_ll(32'h100, 32'h0);
    repeat (10) step();
    dmemWEN = 1'b1; datomic = 1'b1; dmemaddr = 32'h100; dmemstore = 32'h4;
    step();
    n_cmp++; if ({dhit, cWEN, dmemload} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL to_late: got %b/%h want 10/0", {dhit, cWEN}, dmemload); end
    idle_in();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_ll_sc();
    test_sc_fail();
    test_snoop();
    test_snoop_ll_same_cycle();
    test_store_link();
    test_priority_and_idle_chit();
    test_reset_mem();
`ifdef LL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atomic_link_unit.md
# atomic_link_unit

Data-side responder for the memory requests that instruction decode produces (dmemREN, dmemWEN, datomic), placed between the datapath and the L1 data cache. The block forwards plain loads and stores to the cache, holds the link register for LL/SC, invalidates the link on coherence snoops, and returns the SC success flag to the datapath. A failed SC completes without generating any cache write.

## Interface
Parameters:
- WORD_W, 32, data and address width.
- TIMEOUT_CYCLES, 1024, link lifetime in cycles; used only when LL_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- datomic  in  1  marks the request as LL (with REN) or SC (with WEN).
- dmemaddr  in  WORD_W  byte address; the low 2 bits are ignored.
- dmemstore  in  WORD_W  store data.
- dhit  out  1  one-cycle completion pulse to the datapath.
- dmemload  out  WORD_W  load data, or the SC result (1 = success, 0 = fail).
- cREN  out  1  cache read request.
- cWEN  out  1  cache write request.
- caddr  out  WORD_W  registered request address.
- cstore  out  WORD_W  registered store data.
- chit  in  1  cache completion for the current cREN/cWEN.
- cload  in  WORD_W  cache read data.
- snoop_inv  in  1  coherence invalidation valid.
- snoop_addr  in  WORD_W  invalidated byte address.

## Operation
**State machine: IDLE, MEM, RESP.**
- **IDLE**
  - The block samples requests only in IDLE.
  - If dmemREN is high, the request is a read. REN takes priority when REN and WEN are both high, and WEN is ignored.
  - On any accepted request, dmemaddr is captured into caddr and dmemstore is captured into cstore.
  - Plain read, plain write, or LL goes to MEM.
  - SC with link_valid=1 and link_addr == dmemaddr[WORD_W-1:2] goes to MEM as a write.
  - SC failing that check goes to RESP.
- **MEM**
  - cREN (reads) or cWEN (writes) is asserted continuously until chit.
  - On chit, dhit=1 in the same cycle and the next state is IDLE.
  - dmemload is cload for reads and 1 for a successful SC.
- **RESP**
  - Lasts exactly one cycle: dhit=1, dmemload=0, cREN=cWEN=0.
  - Next state is IDLE.

**Link register.**
- link_valid is 1 bit; link_addr is WORD_W-2 bits.
- LL completion (chit in MEM) sets link_valid=1 and link_addr=caddr[WORD_W-1:2].
- Any SC completion clears link_valid, whether it succeeds or fails.
- A plain store completing to link_addr clears link_valid.
- In any state, snoop_inv=1 with snoop_addr[WORD_W-1:2]==link_addr clears link_valid.
- If a snoop arrives in the same cycle as an LL completion to the same word, the snoop wins and link_valid ends at 0.
- SC success is decided in IDLE. A snoop arriving after the SC has entered MEM does not abort the write.
- Outputs when not requesting: dmemload=0, cREN=cWEN=0, and caddr/cstore hold their last value.
- The datapath holds its request stable until dhit and deasserts it in the following cycle.

## Timing
- Reset (nRST low, takes effect immediately):
  - State goes to IDLE.
  - link_valid=0, link_addr=0.
  - dhit=0, dmemload=0, cREN=0, cWEN=0, caddr=0, cstore=0.
- Reset during MEM drops cREN/cWEN immediately. No dhit is produced.
- Latency:
  - A cache access takes at least 2 cycles: the request is accepted in cycle 0, cREN/cWEN are asserted from cycle 1, and dhit arrives in the cycle of chit.
  - A failed SC takes exactly 2 cycles, with dhit in cycle 1.
- dhit never stays high for two consecutive cycles.
- chit is ignored outside MEM.
- The address compare ignores bits [1:0].

## Configuration
- Macro LL_TIMEOUT_EN.
- Defined:
  - A counter is loaded with TIMEOUT_CYCLES on LL completion and decrements every cycle while link_valid=1.
  - When the counter reaches 0, link_valid clears.
  - A new LL reloads the counter.
  - A subsequent SC succeeds only while the counter is nonzero.
- Undefined: no counter is built, and the link persists until an SC completes, a store to the linked word completes, a matching snoop arrives, or reset.

## Test plan
- LL to 0x100 returns cload=0xDEADBEEF with chit on the first MEM cycle → dhit in cycle 1 with dmemload=0xDEADBEEF, link_valid=1 and link_addr=0x40. Then SC to 0x100 with store data 0x5 → cWEN=1, cstore=0x5, dmemload=1, link_valid=0.
- SC to 0x200 without a prior LL → RESP, dhit=1 with dmemload=0, no cWEN ever asserted.
- LL to 0x100, then snoop_inv with snoop_addr=0x104 (different word) → link stays valid. Then snoop_addr=0x103 (same word) → link cleared, and a following SC returns 0.
- Snoop on 0x100 in the same cycle as an LL 0x100 chit → link_valid=0 afterwards.
- nRST low while in MEM with cREN=1 → cREN=0 that cycle, no dhit. After release, a plain LW to 0x10 completes normally.
- With LL_TIMEOUT_EN and TIMEOUT_CYCLES=8:
  - SC issued 4 cycles after LL completion succeeds.
  - SC issued 10 cycles after LL completion returns 0.
